proj_to_affine: RTL and testbench



---
 rtl/proj_to_affine.sv | 216 +++++++++++++++++++++
 tb/tb_proj_to_affine.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/proj_to_affine.sv
// proj_to_affine
//   Converts a projective point (X, Y, Z) over GF(P) to affine form:
//   x = X * Z^-1 mod P, y = Y * Z^-1 mod P.
//   Z^-1 is computed as Z^(P-2) by left-to-right square-and-multiply.
//   One bit-serial interleaved modular multiplier is shared by all products;
//   each product takes W+1 cycles (one load cycle plus W iterations).
//
//   The parameters may be overridden with another prime, provided that
//   2^(W-1) < P < 2^W and bit W-1 of P-2 is set. These conditions make one
//   conditional subtract enough to reduce an input, and let the exponent scan
//   start at bit W-2 with acc = Z.
//
// Ports
//   i_clk       clock
//   i_rst       synchronous, active-high reset
//   i_start     single-cycle request, sampled only in IDLE
//   i_x/i_y/i_z projective coordinates (need not be reduced)
//   o_x/o_y     affine result, valid with o_finished, held until the next DONE
//   o_finished  one-cycle done pulse
//   o_busy      high from the cycle after acceptance through the o_finished cycle
//   o_invalid   set with o_finished when Z == 0 mod P, cleared on the next start
//
// State table
//   state     | meaning
//   IDLE      | waiting for i_start
//   CHECK     | test reduced Z for zero, seed acc = Z
//   INV_SQ    | acc = acc * acc
//   INV_MUL   | acc = acc * Z (exponent bit set)
//   MUL_X     | x = X * Z^-1
//   MUL_Y     | y = Y * Z^-1
//   DONE      | o_x/o_y updated, o_finished pulse

module proj_to_affine #(
  parameter int              W = 255,
  parameter logic [W-1:0]    P = {{250{1'b1}}, 5'b01101}
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic [W-1:0] i_z,
  output logic [W-1:0] o_x,
  output logic [W-1:0] o_y,
  output logic         o_finished,
  output logic         o_busy,
  output logic         o_invalid
);

  localparam int           EW = $clog2(W);
  localparam int           CW = $clog2(W + 1);
  localparam logic [W-1:0] E  = P - W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_INV_SQ,
    S_INV_MUL,
    S_MUL_X,
    S_MUL_Y,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]  r_x;      // reduced X; reused to hold x between MUL_X and DONE
  logic [W-1:0]  r_y;
  logic [W-1:0]  r_z;
  logic [W-1:0]  r_acc;
  logic [EW-1:0] r_e;
  logic [W-1:0]  r_ma;
  logic [W-1:0]  r_mb;
  logic [W-1:0]  r_mr;
  logic [CW-1:0] r_cnt;
  logic          r_loaded;
  logic [W-1:0]  r_ox;
  logic [W-1:0]  r_oy;
  logic          r_invalid;

  logic [W+1:0]  w_pext;
  logic [W+1:0]  w_sum;
  logic [W+1:0]  w_sub1;
  logic [W-1:0]  w_mul_res;
  logic          w_mul_done;
  logic          w_ebit;
  logic [W-1:0]  w_op_a;
  logic [W-1:0]  w_op_b;

  function automatic logic [W-1:0] reduce(input logic [W-1:0] v);
    return (v >= P) ? v - P : v;
  endfunction

  // One multiplier iteration: r = 2r + b_msb*a, then two conditional
  // subtracts; r < P and a < P keep the sum below 3P.
  assign w_pext    = {2'b00, P};
  assign w_sum     = {1'b0, r_mr, 1'b0} + (r_mb[W-1] ? {2'b00, r_ma} : '0);
  assign w_sub1    = (w_sum >= w_pext) ? w_sum - w_pext : w_sum;
  assign w_mul_res = (w_sub1 >= w_pext) ? W'(w_sub1 - w_pext) : W'(w_sub1);

  // The final iteration's result is written on the same edge the FSM leaves.
  assign w_mul_done = r_loaded && (r_cnt == CW'(1));
  assign w_ebit     = E[r_e];

  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    case (r_state)
      S_INV_SQ:  begin w_op_a = r_acc; w_op_b = r_acc; end
      S_INV_MUL: begin w_op_a = r_acc; w_op_b = r_z;   end
      S_MUL_X:   begin w_op_a = r_x;   w_op_b = r_acc; end
      S_MUL_Y:   begin w_op_a = r_y;   w_op_b = r_acc; end
      default:   ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_state_nxt = S_CHECK;
      S_CHECK:   w_state_nxt = (r_z == '0) ? S_DONE : S_INV_SQ;
      S_INV_SQ:
        if (w_mul_done) begin
          if (w_ebit)              w_state_nxt = S_INV_MUL;
          else if (r_e == '0)      w_state_nxt = S_MUL_X;
        end
      S_INV_MUL:
        if (w_mul_done) w_state_nxt = (r_e == '0) ? S_MUL_X : S_INV_SQ;
      S_MUL_X:   if (w_mul_done) w_state_nxt = S_MUL_Y;
      S_MUL_Y:   if (w_mul_done) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_acc     <= '0;
      r_e       <= '0;
      r_ma      <= '0;
      r_mb      <= '0;
      r_mr      <= '0;
      r_cnt     <= '0;
      r_loaded  <= 1'b0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_invalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:
          if (i_start) begin
            r_x       <= reduce(i_x);
            r_y       <= reduce(i_y);
            r_z       <= reduce(i_z);
            r_invalid <= 1'b0;
          end
        S_CHECK:
          if (r_z == '0) begin
            r_ox      <= '0;
            r_oy      <= '0;
            r_invalid <= 1'b1;
          end else begin
            r_acc <= r_z;
            r_e   <= EW'(W - 2);
          end
        S_INV_SQ, S_INV_MUL, S_MUL_X, S_MUL_Y:
          if (!r_loaded) begin
            r_ma     <= w_op_a;
            r_mb     <= w_op_b;
            r_mr     <= '0;
            r_cnt    <= CW'(W);
            r_loaded <= 1'b1;
          end else begin
            r_mr  <= w_mul_res;
            r_mb  <= r_mb << 1;
            r_cnt <= r_cnt - CW'(1);
            if (w_mul_done) begin
              r_loaded <= 1'b0;
              case (r_state)
                S_INV_SQ: begin
                  r_acc <= w_mul_res;
                  if (!w_ebit && r_e != '0) r_e <= r_e - EW'(1);
                end
                S_INV_MUL: begin
                  r_acc <= w_mul_res;
                  if (r_e != '0) r_e <= r_e - EW'(1);
                end
                S_MUL_X: r_x <= w_mul_res;
                S_MUL_Y: begin
                  r_ox <= r_x;
                  r_oy <= w_mul_res;
                end
                default: ;
              endcase
            end
          end
        default: ;
      endcase
    end
  end

  assign o_x        = r_ox;
  assign o_y        = r_oy;
  assign o_invalid  = r_invalid;
  assign o_finished = (r_state == S_DONE);
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_proj_to_affine.sv
// Bench for proj_to_affine, run on a 16-bit prime field (P = 65521) so every
// operation stays short; the reference uses extended Euclid for Z^-1.
module tb_proj_to_affine;

  localparam int           W  = 16;
  localparam logic [W-1:0] P  = 16'hFFF1;
  localparam longint       PL = 65521;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_start = 1'b0;
  logic [W-1:0] i_x = '0, i_y = '0, i_z = '0;
  logic [W-1:0] o_x, o_y;
  logic         o_finished, o_busy, o_invalid;

  int n_total = 0;
  int n_bad   = 0;
  int lat_ok;

  proj_to_affine #(.W(W), .P(P)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_x(i_x), .i_y(i_y), .i_z(i_z),
    .o_x(o_x), .o_y(o_y),
    .o_finished(o_finished), .o_busy(o_busy), .o_invalid(o_invalid)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint inv_mod(input longint a);
    longint t = 0, nt = 1, r = PL, nr = a, q, tmp;
    while (nr != 0) begin
      q = r / nr;
      tmp = t - q * nt; t = nt; nt = tmp;
      tmp = r - q * nr; r = nr; nr = tmp;
    end
    if (t < 0) t += PL;
    return t;
  endfunction

  // Latency from the exponent's bit pattern: one squaring per bit below the
  // top bit of P-2, one multiply per set bit among those, plus the two
  // coordinate products, each costing W+1 cycles, after capture and check.
  function automatic int valid_latency();
    longint e = PL - 2;
    int ops = 2;
    for (int b = W - 2; b >= 0; b--) begin
      ops++;
      if ((e >> b) & 1) ops++;
    end
    return 2 + ops * (W + 1);
  endfunction

  // mode 0: plain run, mode 1: extra start pulses mid-run, mode 2: reset at cycle 300
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] z, input int mode);
    longint xr, yr, zr, zi, ex, ey;
    int     exp_lat, cyc, lim;
    logic   exp_inv;
    xr = longint'(x) % PL;
    yr = longint'(y) % PL;
    zr = longint'(z) % PL;
    exp_inv = (zr == 0);
    if (exp_inv) begin ex = 0; ey = 0; exp_lat = 2; end
    else begin
      zi = inv_mod(zr);
      ex = (xr * zi) % PL;
      ey = (yr * zi) % PL;
      exp_lat = lat_ok;
    end
    lim = lat_ok + 50;
    i_x = x; i_y = y; i_z = z; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_x = W'($urandom); i_y = W'($urandom); i_z = W'($urandom);
    cyc = 1;
    check_val({tag, ".busy_c1"}, longint'(o_busy), 1);
    check_val({tag, ".inv_c1"}, longint'(o_invalid), 0);
    while (!o_finished && cyc < lim) begin
      if (mode == 1) i_start = (cyc == 100 || cyc == 400);
      if (mode == 2 && cyc == 300) begin
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        cyc++;
        check_val({tag, ".rst_x"}, longint'(o_x), 0);
        check_val({tag, ".rst_y"}, longint'(o_y), 0);
        check_val({tag, ".rst_busy"}, longint'(o_busy), 0);
        check_val({tag, ".rst_inv"}, longint'(o_invalid), 0);
        check_val({tag, ".rst_fin"}, longint'(o_finished), 0);
      end else begin
        @(posedge i_clk); #1;
        cyc++;
      end
    end
    i_start = 1'b0;
    if (mode == 2) begin
      check_val({tag, ".no_finish"}, longint'(o_finished), 0);
      return;
    end
    check_val({tag, ".latency"}, cyc, exp_lat);
    check_val({tag, ".x"}, longint'(o_x), ex);
    check_val({tag, ".y"}, longint'(o_y), ey);
    check_val({tag, ".invalid"}, longint'(o_invalid), longint'(exp_inv));
    check_val({tag, ".busy_fin"}, longint'(o_busy), 1);
    @(posedge i_clk); #1;
    check_val({tag, ".pulse"}, longint'(o_finished), 0);
    check_val({tag, ".idle"}, longint'(o_busy), 0);
    check_val({tag, ".hold_x"}, longint'(o_x), ex);
  endtask

  initial begin
    logic [W-1:0] rx, ry, rz;
    lat_ok = valid_latency();
    repeat (3) @(posedge i_clk);
    #1;
    check_val("rst.x", longint'(o_x), 0);
    check_val("rst.y", longint'(o_y), 0);
    check_val("rst.fin", longint'(o_finished), 0);
    check_val("rst.busy", longint'(o_busy), 0);
    check_val("rst.inv", longint'(o_invalid), 0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    run_op("neutral", 16'd0, 16'd1, 16'd1, 0);
    run_op("x2y4z2", 16'd2, 16'd4, 16'd2, 0);
    run_op("zpm1", 16'd5, 16'd7, P - 16'd1, 0);
    run_op("unreduced", P + 16'd3, P, 16'd1, 0);
    run_op("z_zero", 16'd9, 16'd11, 16'd0, 0);
    run_op("z_eq_p", 16'd9, 16'd11, P, 0);
    run_op("after_inv", 16'd3, 16'd8, 16'd5, 0);

    for (int i = 0; i < 50; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      do rz = W'($urandom); while ((longint'(rz) % PL) == 0);
      run_op($sformatf("rnd%0d", i), rx, ry, rz, 0);
    end

    run_op("start_pokes", 16'd1234, 16'd4321, 16'd777, 1);
    run_op("mid_reset", 16'd100, 16'd200, 16'd300, 2);
    run_op("post_reset", 16'd100, 16'd200, 16'd300, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
